sync_ram: RTL and testbench

Parametrised synchronous single-port RAM with a valid/ready request interface, per-byte write enables, a one-cycle registered read response, and a hardware clear sweep after reset. It succeeds the team's 16x8 asynchronous inout RAM. It sits between a bus master and local storage wherever a clocked, initialised scratch memory is needed.

---
 rtl/sync_ram_pkg.sv | 29 ++
 rtl/sync_ram_array.sv | 52 +++++
 rtl/sync_ram.sv | 152 +++++++++++++++
 tb/tb_sync_ram.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/sync_ram_pkg.sv
// ---------------------------------------------------------------------------
// sync_ram_pkg
//   Shared types and elaboration helpers for the sync_ram block.
//   Contents: controller state encoding, byte-enable width helper and the
//   parameter legality check used at elaboration time.
//   Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package sync_ram_pkg;

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  // Number of byte lanes for a given data width.
  function automatic int calc_be_w(input int data_w);
    return data_w / 8;
  endfunction

  // True when the parameter set describes a buildable memory.
  function automatic bit params_ok(input int data_w, input int addr_w, input int depth);
    return ((data_w % 8) == 0) && (data_w >= 8) && (depth >= 1) && (depth <= (1 << addr_w));
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_ram_array.sv
// ---------------------------------------------------------------------------
// sync_ram_array
//   DEPTH x DATA_W storage with a byte-enabled write port and a registered
//   read port sharing one address. The array and read register have no reset.
//   Ports:
//     clk      - clock
//     we_i     - write strobe
//     be_i     - byte enables for the write
//     re_i     - read strobe; loads rdata_o on the next edge
//     addr_i   - word address (caller guarantees addr_i < DEPTH when strobed)
//     wdata_i  - write data
//     rdata_o  - registered read data, holds between reads
//   Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module sync_ram_array #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16,
  parameter int BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [BE_W-1:0]   be_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int b = 0; b < BE_W; b++) begin
        if (be_i[b]) begin
          mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/sync_ram.sv
// ---------------------------------------------------------------------------
// sync_ram
//   Synchronous single-port RAM with valid/ready requests, byte enables,
//   one-cycle registered read response and a clear sweep after reset.
//   Ports:
//     clk, rst                - clock, async active-high reset
//     req_valid/req_ready     - request handshake
//     req_we, req_addr,
//     req_wdata, req_be       - request payload
//     rsp_valid, rsp_rdata,
//     rsp_err                 - read response (one-cycle pulse)
//     wr_err                  - out-of-range write pulse
//     init_done               - clear sweep finished
//   Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module sync_ram
  import sync_ram_pkg::*;
#(
  parameter int                 DATA_W   = 8,
  parameter int                 ADDR_W   = 4,
  parameter int                 DEPTH    = 2**ADDR_W,
  parameter logic [DATA_W-1:0]  INIT_VAL = '0,
  localparam int                BE_W     = calc_be_w(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              wr_err,
  output logic              init_done
);

  generate
    if (!params_ok(DATA_W, ADDR_W, DEPTH)) begin : g_bad_params
      $error("sync_ram: DATA_W must be a multiple of 8 and 1 <= DEPTH <= 2**ADDR_W");
    end
  endgenerate

  // One extra bit so DEPTH == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0]   C_DEPTH = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] C_LAST  = ADDR_W'(DEPTH - 1);

  state_t            state_q;
  logic [ADDR_W-1:0] sweep_q;
  logic              ready_q;
  logic              init_done_q;
  logic              rsp_valid_q;
  logic              rsp_err_q;
  logic              wr_err_q;
  logic              rd_zero_q;   // forces rsp_rdata to 0 (reset / out-of-range read)

  logic              accept;
  logic              in_range;
  logic              sweeping;
  logic              arr_we;
  logic              arr_re;
  logic [BE_W-1:0]   arr_be;
  logic [ADDR_W-1:0] arr_addr;
  logic [DATA_W-1:0] arr_wdata;
  logic [DATA_W-1:0] arr_rdata;

  assign accept   = req_valid && ready_q;
  assign in_range = ({1'b0, req_addr} < C_DEPTH);
  assign sweeping = (state_q == ST_INIT);

  // Sweep owns the port during INIT; requests are never accepted then.
  assign arr_we    = sweeping || (accept && req_we && in_range);
  assign arr_re    = accept && !req_we && in_range;
  assign arr_be    = sweeping ? '1       : req_be;
  assign arr_addr  = sweeping ? sweep_q  : req_addr;
  assign arr_wdata = sweeping ? INIT_VAL : req_wdata;

  sync_ram_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .BE_W   (BE_W)
  ) u_array (
    .clk     (clk),
    .we_i    (arr_we),
    .be_i    (arr_be),
    .re_i    (arr_re),
    .addr_i  (arr_addr),
    .wdata_i (arr_wdata),
    .rdata_o (arr_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_INIT;
      sweep_q     <= '0;
      ready_q     <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          if (sweep_q == C_LAST) begin
            state_q     <= ST_READY;
            ready_q     <= 1'b1;
            init_done_q <= 1'b1;
          end else begin
            sweep_q <= sweep_q + 1'b1;
          end
        end
        ST_READY: begin
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= ST_INIT;
          sweep_q <= '0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      wr_err_q    <= 1'b0;
      rd_zero_q   <= 1'b1;
    end else begin
      rsp_valid_q <= accept && !req_we;
      rsp_err_q   <= accept && !req_we && !in_range;
      wr_err_q    <= accept && req_we && !in_range;
      // Only a new read changes what the data pins show; otherwise they hold.
      if (accept && !req_we) begin
        rd_zero_q <= !in_range;
      end
    end
  end

  assign req_ready = ready_q;
  assign init_done = init_done_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign wr_err    = wr_err_q;
  assign rsp_rdata = rd_zero_q ? '0 : arr_rdata;

endmodule

`default_nettype wire

// File: tb/tb_sync_ram.sv
// ---------------------------------------------------------------------------
// tb_sync_ram
//   Directed self-checking bench for sync_ram (DATA_W=16, ADDR_W=4,
//   DEPTH=12, INIT_VAL=16'hA5A5).
//   Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_sync_ram;

  localparam int          DATA_W = 16;
  localparam int          ADDR_W = 4;
  localparam int          DEPTH  = 12;
  localparam logic [15:0] C_INIT = 16'hA5A5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [3:0]  req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic [1:0]  req_be = '0;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic        wr_err;
  logic        init_done;

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] model [DEPTH];

  always #5 clk = ~clk;

  sync_ram #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH),
    .INIT_VAL (C_INIT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .wr_err    (wr_err),
    .init_done (init_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic v, input logic we, input logic [3:0] a,
                         input logic [15:0] d, input logic [1:0] be);
    req_valid = v;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    req_be    = be;
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d, input logic [1:0] be);
    set_req(1'b1, 1'b1, a, d, be);
    tick();
    set_req(1'b0, 1'b0, 4'd0, 16'h0, 2'b00);
  endtask

  task automatic rd(input string tag, input logic [3:0] a, input logic [15:0] exp, input logic err);
    set_req(1'b1, 1'b0, a, 16'h0, 2'b00);
    tick();
    set_req(1'b0, 1'b0, 4'd0, 16'h0, 2'b00);
    chk({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
    chk({tag, "_data"},  {16'd0, rsp_rdata}, {16'd0, exp});
    chk({tag, "_err"},   {31'd0, rsp_err},   {31'd0, err});
  endtask

  // Counts edges after rst release until init_done; bounded.
  task automatic wait_init(output int n);
    n = 0;
    while (!init_done && n < 40) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    int stray;

    // ---- Reset values ----
    tick();
    tick();
    chk("rst_ready",  {31'd0, req_ready}, 32'd0);
    chk("rst_valid",  {31'd0, rsp_valid}, 32'd0);
    chk("rst_rdata",  {16'd0, rsp_rdata}, 32'd0);
    chk("rst_err",    {31'd0, rsp_err},   32'd0);
    chk("rst_wrerr",  {31'd0, wr_err},    32'd0);
    chk("rst_done",   {31'd0, init_done}, 32'd0);

    // ---- 1: sweep length and contents ----
    rst = 1'b0;
    wait_init(n);
    chk("sweep_edges", n, 32'd12);
    chk("sweep_ready", {31'd0, req_ready}, 32'd1);
    for (int i = 0; i < DEPTH; i++) model[i] = C_INIT;
    for (int i = 0; i < DEPTH; i++) rd("sweep_rd", 4'(i), model[i], 1'b0);

    // ---- 2: byte enables ----
    wr(4'd3, 16'h1234, 2'b11);
    wr(4'd3, 16'hFF00, 2'b10);
    rd("be_hi", 4'd3, 16'hFF34, 1'b0);
    wr(4'd3, 16'h0000, 2'b00);
    rd("be_none", 4'd3, 16'hFF34, 1'b0);
    model[3] = 16'hFF34;

    // ---- 3: back-to-back write, read, read ----
    set_req(1'b1, 1'b1, 4'd5, 16'hBEEF, 2'b11);
    tick();
    chk("b2b_wr_norsp", {31'd0, rsp_valid}, 32'd0);
    set_req(1'b1, 1'b0, 4'd5, 16'h0, 2'b00);
    tick();
    chk("b2b_rd5_valid", {31'd0, rsp_valid}, 32'd1);
    chk("b2b_rd5_data",  {16'd0, rsp_rdata}, 32'h0000BEEF);
    set_req(1'b1, 1'b0, 4'd0, 16'h0, 2'b00);
    tick();
    set_req(1'b0, 1'b0, 4'd0, 16'h0, 2'b00);
    chk("b2b_rd0_valid", {31'd0, rsp_valid}, 32'd1);
    chk("b2b_rd0_data",  {16'd0, rsp_rdata}, 32'h0000A5A5);
    model[5] = 16'hBEEF;
    tick();
    chk("b2b_pulse_end", {31'd0, rsp_valid}, 32'd0);
    chk("hold_rdata",    {16'd0, rsp_rdata}, 32'h0000A5A5);

    // ---- 4: out of range ----
    wr(4'd13, 16'h5555, 2'b11);
    chk("oor_wrerr", {31'd0, wr_err}, 32'd1);
    tick();
    chk("oor_wrerr_pulse", {31'd0, wr_err}, 32'd0);
    for (int i = 0; i < DEPTH; i++) rd("oor_keep", 4'(i), model[i], 1'b0);
    rd("oor_rd15", 4'd15, 16'h0000, 1'b1);
    tick();
    chk("oor_err_pulse", {31'd0, rsp_err}, 32'd0);

    // ---- 5: reset mid-operation ----
    set_req(1'b1, 1'b0, 4'd3, 16'h0, 2'b00);
    tick();
    set_req(1'b0, 1'b0, 4'd0, 16'h0, 2'b00);
    rst = 1'b1;
    #1;
    chk("midrst_norsp", {31'd0, rsp_valid}, 32'd0);
    tick();
    chk("midrst_norsp2", {31'd0, rsp_valid}, 32'd0);
    chk("midrst_done",   {31'd0, init_done}, 32'd0);
    rst = 1'b0;
    repeat (6) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_init(n);
    chk("resweep_edges", n, 32'd12);
    rd("resweep_a3", 4'd3, C_INIT, 1'b0);
    rd("resweep_a5", 4'd5, C_INIT, 1'b0);

    // ---- 6: ready gating with request held through INIT ----
    rst = 1'b1;
    set_req(1'b1, 1'b1, 4'd7, 16'h7777, 2'b11);
    tick();
    rst = 1'b0;
    n = 0;
    stray = 0;
    while (!init_done && n < 40) begin
      if (req_ready || wr_err || rsp_valid) stray++;
      tick();
      n++;
    end
    chk("gate_edges", n, 32'd12);
    chk("gate_no_accept", stray, 32'd0);
    tick();
    set_req(1'b0, 1'b0, 4'd0, 16'h0, 2'b00);
    rd("gate_a7", 4'd7, 16'h7777, 1'b0);
    rd("gate_a6", 4'd6, C_INIT, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
